acc_drain: RTL
==============

# acc_drain

Read-side counterpart to the two-entry result accumulator. Snapshots `acc_mem_0`/`acc_mem_1` when the accumulator raises `full` (or on an explicit request). Streams the two 32-bit words, one per handshake, into the unified buffer write port at consecutive addresses from a programmable base. Sits between the accumulator and the unified buffer in the systolic-array datapath.

## Interface
Parameters:
- `DATA_W`, 32, width of each accumulator word and buffer write data
- `ADDR_W`, 8, unified buffer address width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `full`  in  1  accumulator full flag (level; stays high once set)
- `acc_mem_0`  in  DATA_W  accumulator entry 0
- `acc_mem_1`  in  DATA_W  accumulator entry 1
- `drain_req`  in  1  one-cycle request to re-drain current accumulator contents
- `base_addr`  in  ADDR_W  buffer address for entry 0; sampled at trigger
- `ub_wr_en`  out  1  write valid to unified buffer
- `ub_wr_addr`  out  ADDR_W  write address
- `ub_wr_data`  out  DATA_W  write data
- `ub_wr_ready`  in  1  buffer accepts write this cycle
- `busy`  out  1  drain in progress
- `done`  out  1  one-cycle pulse after last word accepted
- `overrun`  out  1  sticky: trigger arrived while busy

## Operation
- Internal `full_q` register; rising edge `full_rise = full & ~full_q`.
- Trigger = `full_rise | drain_req`. Simultaneous `full_rise` and `drain_req` counts as one trigger.
- States: IDLE, WR0, WR1, DONE.
- IDLE: on trigger, capture `acc_mem_0`, `acc_mem_1`, `base_addr` into snapshot registers. Go to WR0.
- WR0: `ub_wr_en=1`, addr = base, data = snap0. On `ub_wr_ready`, go to WR1.
- WR1: `ub_wr_en=1`, addr = base+1 (mod 2^ADDR_W, wraps 0xFF->0x00), data = snap1. On `ub_wr_ready`, go to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE. A trigger seen in DONE is treated as overrun, not queued.
- `busy=1` in WR0, WR1 and DONE.
- Any trigger while not IDLE:
  - ignored; snapshot unchanged
  - sets `overrun`, which holds until reset.
- Snapshot is immune to accumulator changes after capture. Words written are exactly the values present in the trigger cycle.
- Zero-valued words are written like any other value; no skipping.

## Timing
- Reset (synchronous) drives all of the following to 0:
  - state -> IDLE
  - `full_q`, `ub_wr_en`, `ub_wr_addr`, `ub_wr_data`, `busy`, `done`, `overrun`, snapshots
- Reset mid-drain aborts immediately. No further writes; no `done`.
- `full_q` resets to 0, so `full` already high in the first post-reset cycle triggers a drain.
- Trigger sampled at edge T: `ub_wr_en` high from cycle T+1 (registered output).
- Transfer occurs at an edge where `ub_wr_en & ub_wr_ready`.
- `ub_wr_addr`/`ub_wr_data` hold stable while `ub_wr_en & ~ub_wr_ready`.
- With `ub_wr_ready` tied high:
  - entry 0 is accepted at edge T+1, entry 1 at edge T+2
  - `done` is high in cycle T+3
  - IDLE from T+4; next trigger is accepted at edge T+4
- Minimum trigger-to-trigger spacing: 4 cycles.
- `ub_wr_en` never asserts in IDLE or DONE.

## Test plan
- Reset, then `base_addr=0x10`, `acc_mem_0=5`, `acc_mem_1=7`, raise `full`, ready tied 1 -> writes (0x10,5) at T+1 and (0x11,7) at T+2; `done` pulse at T+3; busy low at T+4.
- Same stimulus, `ub_wr_ready` low for 3 cycles during WR0 -> addr 0x10 / data 5 held all 3 cycles; second write follows the first accepted edge; `done` delayed by 3.
- `base_addr=0xFF`, values 1/2 -> writes to 0xFF then 0x00.
- After capture, change `acc_mem_0` to 99 during WR0 stall -> written data still original snapshot; pulse `drain_req` during WR1 -> `overrun=1`, no extra writes, `done` single pulse.
- `full` held high for 20 cycles -> exactly one drain. Then `drain_req` pulse -> second drain of current values. `drain_req` and `full_rise` in the same cycle -> one drain.
- Assert `reset` in WR1 with ready low -> next cycle `ub_wr_en=0`, busy=0, no `done`. `full` still high after reset -> new drain triggered.

Source files
------------

// File: rtl/acc_drain.sv
// acc_drain: read-side drain engine for the two-entry result accumulator.
// It snapshots both accumulator words and the base address when a trigger
// arrives: a rising edge of full, or a one-cycle drain_req pulse. It then
// writes the two words to the unified buffer at base and base+1, using the
// ub_wr_en/ub_wr_ready handshake for each word.
//
// State table:
//   IDLE | waiting for a trigger (full rising edge or drain_req)
//   WR0  | presenting snapshot word 0 at base address
//   WR1  | presenting snapshot word 1 at base address + 1 (wraps)
//   DONE | one-cycle done pulse; a trigger here is an overrun
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   full                  accumulator full level
//   acc_mem_0/acc_mem_1   accumulator words (sampled at trigger)
//   drain_req             one-cycle request to re-drain current contents
//   base_addr             buffer address of word 0 (sampled at trigger)
//   ub_wr_en/addr/data    buffer write port (registered)
//   ub_wr_ready           buffer accepts the presented word this cycle
//   busy                  drain in progress (WR0, WR1, DONE)
//   done                  one-cycle pulse after the last word is accepted
//   overrun               sticky: a trigger arrived while not idle
module acc_drain #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              full,
   input  logic [DATA_W-1:0] acc_mem_0,
   input  logic [DATA_W-1:0] acc_mem_1,
   input  logic              drain_req,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              ub_wr_en,
   output logic [ADDR_W-1:0] ub_wr_addr,
   output logic [DATA_W-1:0] ub_wr_data,
   input  logic              ub_wr_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, WR0, WR1, DONE} state_t;

   state_t            state_q, state_d;
   logic              full_q;
   logic              trigger;
   logic [DATA_W-1:0] snap0_q, snap0_d;
   logic [DATA_W-1:0] snap1_q, snap1_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              en_d, busy_d, done_d, overrun_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      state_d   = state_q;
      snap0_d   = snap0_q;
      snap1_d   = snap1_q;
      base_d    = base_q;
      overrun_d = overrun;
      trigger   = (full & ~full_q) | drain_req;

      case (state_q)
         IDLE: begin
            if (trigger) begin
               snap0_d = acc_mem_0;
               snap1_d = acc_mem_1;
               base_d  = base_addr;
               state_d = WR0;
            end
         end
         WR0:     if (ub_wr_ready) state_d = WR1;
         WR1:     if (ub_wr_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Triggers outside IDLE are dropped; only the sticky flag records them.
      if (trigger && (state_q != IDLE)) overrun_d = 1'b1;

      // Outputs are decoded from the next state and registered. As a result,
      // they change on the same edge as the state and do not glitch.
      en_d   = (state_d == WR0) || (state_d == WR1);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      addr_d = '0;
      data_d = '0;
      if (state_d == WR0) begin
         addr_d = base_d;
         data_d = snap0_d;
      end else if (state_d == WR1) begin
         addr_d = base_d + ADDR_W'(1);
         data_d = snap1_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         full_q     <= 1'b0;
         snap0_q    <= '0;
         snap1_q    <= '0;
         base_q     <= '0;
         ub_wr_en   <= 1'b0;
         ub_wr_addr <= '0;
         ub_wr_data <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         full_q     <= full;
         snap0_q    <= snap0_d;
         snap1_q    <= snap1_d;
         base_q     <= base_d;
         ub_wr_en   <= en_d;
         ub_wr_addr <= addr_d;
         ub_wr_data <= data_d;
         busy       <= busy_d;
         done       <= done_d;
         overrun    <= overrun_d;
      end
   end

endmodule
